// File: rtl/spi_ctrl_pkg.sv
// Shared constants, register map and FSM encoding for the SPI write scheduler.
// The write frame is {R/W, ADDR[6:0], DATA[7:0]}, shifted out MSB first.
package spi_ctrl_pkg;

  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned FRAME_W = 16;

  localparam logic [ADDR_W-1:0] MAX_ADDR  = 7'h04;
  localparam logic              WRITE_BIT = 1'b1;

  localparam logic [ADDR_W-1:0] EN_OUT_LO = 7'h00;
  localparam logic [ADDR_W-1:0] EN_OUT_HI = 7'h01;
  localparam logic [ADDR_W-1:0] EN_PWM_LO = 7'h02;
  localparam logic [ADDR_W-1:0] EN_PWM_HI = 7'h03;
  localparam logic [ADDR_W-1:0] PWM_DUTY  = 7'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT_HI,
    ST_SHIFT_LO,
    ST_GAP
  } spi_state_e;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a <= MAX_ADDR);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from the pointer with wrap;
// the pointer moves past the granted requester when advance is asserted.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       en,
  input  logic                       advance,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic                       gnt_any
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  int unsigned      j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (en && !gnt_any && req[j]) begin
        gnt_any = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && gnt_any) begin
      if (int'(gnt_idx) == NUM_REQ - 1) ptr_d = '0;
      else                              ptr_d = gnt_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/spi_write_scheduler.sv
// Shares one SPI Mode 0 link between NUM_REQ requesters; each accepted write
// becomes a 16-bit frame {1, addr, data}. Invalid addresses are acknowledged and flagged.
module spi_write_scheduler
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*7-1:0]       req_addr,
  input  logic [NUM_REQ*8-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic                       nCS,
  output logic                       SCLK,
  output logic                       COPI
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam int unsigned HC_W = $clog2(CLK_DIV);
  localparam int unsigned GC_W = $clog2(CS_GAP);

  spi_state_e           state_q, state_d;
  logic [HC_W-1:0]      half_q, half_d;
  logic [3:0]           bit_q, bit_d;
  logic [GC_W-1:0]      gap_q, gap_d;
  logic [FRAME_W-1:0]   shreg_q, shreg_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [NUM_REQ-1:0]   gnt;
  logic [ID_W-1:0]      gnt_idx;
  logic                 gnt_any;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_data;
  logic                 half_last;
  logic                 in_frame;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .en      (state_q == ST_IDLE),
    .advance (gnt_any),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        sel_addr = req_addr[k*ADDR_W +: ADDR_W];
        sel_data = req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  assign half_last = (half_q == HC_W'(CLK_DIV - 1));

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    shreg_d = shreg_q;
    grant_d = grant_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          grant_d = gnt_idx;
          if (addr_ok(sel_addr)) begin
            shreg_d = {WRITE_BIT, sel_addr, sel_data};
            half_d  = '0;
            bit_d   = 4'd15;
            state_d = ST_SETUP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (half_last) begin
          half_d  = '0;
          state_d = ST_SHIFT_HI;
        end else begin
          half_d = half_q + HC_W'(1);
        end
      end
      ST_SHIFT_HI: begin
        if (half_last) begin
          half_d  = '0;
          // Shifting here puts the next bit on COPI together with the falling edge.
          shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
          state_d = ST_SHIFT_LO;
        end else begin
          half_d = half_q + HC_W'(1);
        end
      end
      ST_SHIFT_LO: begin
        if (half_last) begin
          half_d = '0;
          if (bit_q == 4'd0) begin
            gap_d   = '0;
            done_d  = 1'b1;
            state_d = ST_GAP;
          end else begin
            bit_d   = bit_q - 4'd1;
            state_d = ST_SHIFT_HI;
          end
        end else begin
          half_d = half_q + HC_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_q == GC_W'(CS_GAP - 1)) state_d = ST_IDLE;
        else                            gap_d   = gap_q + GC_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      half_q  <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      shreg_q <= '0;
      grant_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      shreg_q <= shreg_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign in_frame  = (state_q == ST_SETUP) || (state_q == ST_SHIFT_HI) ||
                     (state_q == ST_SHIFT_LO);
  assign req_ready = gnt;
  assign grant_id  = grant_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign nCS       = ~in_frame;
  assign SCLK      = (state_q == ST_SHIFT_HI);
  assign COPI      = in_frame & shreg_q[FRAME_W-1];

endmodule

// File: tb/tb_spi_write_scheduler.sv
// Randomized scoreboard bench: a cycle-count reference model predicts handshakes and
// pulses, and an SPI peripheral model decodes frames and checks them against the queue.
module tb_spi_write_scheduler;
  import spi_ctrl_pkg::*;

  localparam int unsigned N         = 2;
  localparam int unsigned D         = 4;
  localparam int unsigned G         = 4;
  localparam int unsigned FRAME_LOW = 33 * D;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*7-1:0] req_addr;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [0:0]     grant_id;
  logic           busy, done, err, nCS, SCLK, COPI;

  spi_write_scheduler #(
    .NUM_REQ (N),
    .CLK_DIV (D),
    .CS_GAP  (G)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .nCS       (nCS),
    .SCLK      (SCLK),
    .COPI      (COPI)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  logic rst_seen = 1'b1;
  always @(posedge clk) rst_seen <= rst;

  logic [15:0] sb[$];
  logic [14:0] wr_log[$];

  // Reference model: whole-frame timing from cycle counts after each accept.
  bit          m_active   = 0;
  int unsigned m_since    = 0;
  bit          m_err_pend = 0;
  int          m_ptr      = 0;
  int          m_gid      = 0;

  always @(negedge clk) begin
    int            w;
    int            jj;
    logic [N-1:0]  exp_ready;
    logic [6:0]    a;
    logic [7:0]    d;
    bit            exp_ncs, exp_sclk;
    if (rst_seen) begin
      check("rst_ncs", nCS, 1);
      check("rst_sclk", SCLK, 0);
      check("rst_copi", COPI, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_grant_id", grant_id, 0);
      check("rst_ready", req_ready, 0);
      m_active = 0; m_since = 0; m_err_pend = 0; m_ptr = 0; m_gid = 0;
      sb.delete();
    end else begin
      if (m_active) m_since++;
      exp_ncs  = !(m_active && m_since <= FRAME_LOW);
      exp_sclk = !exp_ncs && ((((m_since - 1) / D) % 2) == 1);
      check("busy", busy, m_active);
      check("done", done, m_active && m_since == FRAME_LOW + 1);
      check("err", err, m_err_pend);
      check("grant_id", grant_id, m_gid);
      check("ncs", nCS, exp_ncs);
      check("sclk", SCLK, exp_sclk);
      if (exp_ncs) check("copi_idle", COPI, 0);
      m_err_pend = 0;
      w = -1;
      exp_ready = '0;
      if (!m_active) begin
        for (int k = 0; k < N; k++) begin
          jj = (m_ptr + k) % N;
          if (w < 0 && req_valid[jj]) w = jj;
        end
        if (w >= 0) exp_ready[w] = 1'b1;
      end
      check("req_ready", req_ready, exp_ready);
      if (m_active && m_since == FRAME_LOW + G) m_active = 0;
      if (w >= 0 && !rst) begin
        m_gid = w;
        m_ptr = (w + 1) % N;
        a = req_addr[w*7 +: 7];
        d = req_data[w*8 +: 8];
        if (a <= 7'h04) begin
          sb.push_back({1'b1, a, d});
          m_active = 1;
          m_since  = 0;
        end else begin
          m_err_pend = 1;
        end
      end
    end
  end

  // SPI peripheral model: samples COPI on SCLK rising edges while nCS is low.
  logic        p_ncs = 1'b1, p_sclk = 1'b0, p_in = 1'b0;
  logic [15:0] p_bits;
  int unsigned p_nbits, p_low;

  always @(negedge clk) begin
    logic [15:0] e;
    if (rst_seen) begin
      p_in = 1'b0;
    end else begin
      if (p_ncs && nCS) check("sclk_low_while_cs_high", SCLK, 0);
      if (p_sclk && SCLK) check("cs_stable_while_sclk_high", nCS, p_ncs);
      if (!nCS) begin
        if (p_ncs) begin
          p_in = 1'b1; p_bits = '0; p_nbits = 0; p_low = 0;
        end
        p_low++;
        if (!p_sclk && SCLK) begin
          p_bits = {p_bits[14:0], COPI};
          p_nbits++;
        end
      end else if (!p_ncs && p_in) begin
        p_in = 1'b0;
        check("frame_rising_edges", p_nbits, 16);
        check("frame_ncs_low_len", p_low, FRAME_LOW);
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL frame_unexpected: got %0h expected none", p_bits);
        end else begin
          e = sb.pop_front();
          check("frame_bits", p_bits, e);
        end
        if (p_bits[15] && p_bits[14:8] <= 7'h04) wr_log.push_back(p_bits[14:0]);
      end
    end
    p_ncs  = nCS;
    p_sclk = SCLK;
  end

  logic [14:0] pend[N][$];

  task automatic run_engine(input bit force_raise, input int unsigned budget);
    logic [N-1:0] hs;
    logic [14:0]  f;
    int unsigned  cyc = 0;
    bit           empty;
    while (1) begin
      empty = 1;
      for (int i = 0; i < N; i++) if (pend[i].size() != 0) empty = 0;
      if (empty && req_valid == '0 && !busy) break;
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) f = pend[i].pop_front();
        if (pend[i].size() == 0) begin
          req_valid[i] = 1'b0;
        end else if (!(req_valid[i] && !hs[i]) && (force_raise || $urandom_range(1, 0) == 1)) begin
          f = pend[i][0];
          req_valid[i]        = 1'b1;
          req_addr[i*7 +: 7] = f[14:8];
          req_data[i*8 +: 8] = f[7:0];
        end else if (hs[i]) begin
          req_valid[i] = 1'b0;
        end
      end
      cyc++;
      if (cyc > budget) begin
        check("engine_timeout", cyc, budget);
        for (int i = 0; i < N; i++) pend[i].delete();
        req_valid = '0;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  regs[5];
    logic [7:0]  exp_r[5];
    logic [14:0] ent;
    int unsigned base;
    int unsigned wait_cyc;
    rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    pend[0].push_back({7'h04, 8'hA5});
    run_engine(1, 400);
    pend[1].push_back({7'h05, 8'h5A});
    run_engine(1, 50);
    pend[0].push_back({7'h01, 8'h11}); pend[1].push_back({7'h02, 8'h22});
    run_engine(1, 800);
    pend[0].push_back({7'h03, 8'h33}); pend[1].push_back({7'h00, 8'h44});
    run_engine(1, 800);
    for (int k = 0; k < 3; k++) pend[0].push_back({7'(k), 8'(8'hC0 + k)});
    run_engine(1, 1000);

    // Reset in the middle of a frame, after the pointer has moved to requester 1.
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_addr[6:0] = 7'h00; req_data[7:0] = 8'h33;
    wait_cyc = 0;
    while (1) begin
      @(negedge clk);
      if (req_ready[0]) break;
      wait_cyc++;
      if (wait_cyc > 20) begin
        check("midreset_accept_timeout", wait_cyc, 20);
        break;
      end
    end
    @(posedge clk); #1 req_valid = '0;
    repeat (49) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    pend[0].push_back({7'h02, 8'h5C}); pend[1].push_back({7'h01, 8'hC5});
    run_engine(1, 800);

    for (int k = 0; k < 24; k++)
      pend[$urandom_range(N - 1, 0)].push_back({7'($urandom_range(5, 0)), 8'($urandom)});
    run_engine(0, 20000);

    base = wr_log.size();
    pend[0].push_back({EN_OUT_LO, 8'hFF});
    pend[0].push_back({EN_PWM_HI, 8'h0F});
    pend[0].push_back({PWM_DUTY, 8'h80});
    run_engine(1, 1200);
    for (int r = 0; r < 5; r++) begin regs[r] = 8'h00; exp_r[r] = 8'h00; end
    for (int unsigned q = base; q < wr_log.size(); q++) begin
      ent = wr_log[q];
      regs[ent[14:8]] = ent[7:0];
    end
    exp_r[EN_OUT_LO] = 8'hFF;
    exp_r[EN_PWM_HI] = 8'h0F;
    exp_r[PWM_DUTY]  = 8'h80;
    check("reg_en_out_lo", regs[EN_OUT_LO], exp_r[EN_OUT_LO]);
    check("reg_en_out_hi", regs[EN_OUT_HI], exp_r[EN_OUT_HI]);
    check("reg_en_pwm_lo", regs[EN_PWM_LO], exp_r[EN_PWM_LO]);
    check("reg_en_pwm_hi", regs[EN_PWM_HI], exp_r[EN_PWM_HI]);
    check("reg_pwm_duty", regs[PWM_DUTY], exp_r[PWM_DUTY]);

    repeat (5) @(posedge clk);
    #1 check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
